// File: rtl/nfc_apb_regs_pkg.sv
// Shared definitions for the NAND controller APB register front end:
// register offsets, CTRL/STATUS bit positions, FSM encoding, watchdog default.
package nfc_apb_regs_pkg;

   // Word index into the register map, taken from PADDR[4:2]
   localparam logic [2:0] REG_CMD    = 3'd0;
   localparam logic [2:0] REG_ADDR   = 3'd1;
   localparam logic [2:0] REG_LEN    = 3'd2;
   localparam logic [2:0] REG_CTRL   = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;

   localparam int CTRL_START = 0;
   localparam int CTRL_FLUSH = 1;
   localparam int CTRL_IE    = 2;

   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;
   localparam int ST_ERR  = 2;
   localparam int ST_RB   = 3;
   localparam int ST_ACNT = 4;
   localparam int ST_CCNT = 7;
   localparam int ST_TO   = 9;

   localparam int TIMEOUT_DEFAULT = 65535;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } nfc_state_e;

endpackage

// File: rtl/nfc_sync2.sv
// Two-flop synchroniser for the asynchronous NAND ready/busy pin.
// Resets to 1 so the bus reads "ready" until the pin has been sampled.
module nfc_sync2 (
   input  logic PCLK,
   input  logic PRESETN,
   input  logic d,
   output logic q
);

   logic [1:0] ff;

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) ff <= 2'b11;
      else          ff <= {ff[0], d};
   end

   assign q = ff[1];

endmodule

// File: rtl/nfc_apb_regs.sv
// APB3 register front end of the NAND controller: buffers command/address/length,
// strobes the fsm, tracks status and IRQ. Optional watchdog under `NFC_TIMEOUT_EN.
module nfc_apb_regs
   import nfc_apb_regs_pkg::*;
#(
   parameter int ADDR_DEPTH     = 5,
   parameter int CMD_DEPTH      = 2,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic        PCLK,
   input  logic        PRESETN,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [4:0]  PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic [15:0] C_Cmd,
   output logic [39:0] C_Addr,
   output logic [2:0]  C_AddrCnt,
   output logic [7:0]  C_Length,
   output logic        C_Start,
   input  logic        F_Done,
   input  logic        F_Err,
   input  logic        F_nRB,
   output logic        IRQ
);

   localparam logic [1:0] CMD_FULL  = 2'(CMD_DEPTH);
   localparam logic [2:0] ADDR_FULL = 3'(ADDR_DEPTH);

   nfc_state_e  state_q, state_d;
   logic [15:0] cmd_buf;
   logic [39:0] addr_buf;
   logic [1:0]  cmd_cnt;
   logic [2:0]  addr_cnt;
   logic [7:0]  len_q;
   logic        ie_q, done_q, err_q, to_q, irq_q, start_q;
   logic        rb_sync, busy, apb_acc, timeout, fin;
   logic        acc_err, cmd_push, addr_push, len_wr, ctrl_wr, start_ok, flush_ok, stat_w1c;
   logic [2:0]  reg_sel;
   logic [31:0] rdata;
   logic        unused_bits;

   assign unused_bits = ^{PADDR[1:0], PWDATA};

   assign apb_acc = PSEL & PENABLE;
   assign reg_sel = PADDR[4:2];
   assign busy    = (state_q == BUSY);
   assign fin     = busy & (F_Done | timeout);

   nfc_sync2 u_rb_sync (
      .PCLK    (PCLK),
      .PRESETN (PRESETN),
      .d       (F_nRB),
      .q       (rb_sync)
   );

   // Access decode: a rejected access raises PSLVERR and commits nothing
   always_comb begin
      acc_err   = 1'b0;
      cmd_push  = 1'b0;
      addr_push = 1'b0;
      len_wr    = 1'b0;
      ctrl_wr   = 1'b0;
      start_ok  = 1'b0;
      flush_ok  = 1'b0;
      stat_w1c  = 1'b0;
      if (apb_acc) begin
         case (reg_sel)
            REG_CMD: if (PWRITE) begin
               acc_err  = busy || (cmd_cnt == CMD_FULL);
               cmd_push = !acc_err;
            end
            REG_ADDR: if (PWRITE) begin
               acc_err   = busy || (addr_cnt == ADDR_FULL);
               addr_push = !acc_err;
            end
            REG_LEN: if (PWRITE) begin
               acc_err = busy;
               len_wr  = !busy;
            end
            REG_CTRL: if (PWRITE) begin
               // FLUSH takes priority, so START+FLUSH in IDLE is a clean flush
               if (PWDATA[CTRL_FLUSH])      acc_err = busy;
               else if (PWDATA[CTRL_START]) acc_err = busy || (cmd_cnt == 2'd0);
               ctrl_wr  = !acc_err;
               flush_ok = ctrl_wr & PWDATA[CTRL_FLUSH];
               start_ok = ctrl_wr & PWDATA[CTRL_START] & ~PWDATA[CTRL_FLUSH];
            end
            REG_STATUS: stat_w1c = PWRITE;
            default: acc_err = 1'b1;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok) state_d = BUSY;
         BUSY:    if (F_Done || timeout) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         cmd_buf  <= '0;
         addr_buf <= '0;
         cmd_cnt  <= '0;
         addr_cnt <= '0;
         len_q    <= '0;
         ie_q     <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         irq_q    <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         start_q <= start_ok;
         if (cmd_push) begin
            cmd_buf[{cmd_cnt, 3'b000} +: 8] <= PWDATA[7:0];
            cmd_cnt <= cmd_cnt + 2'd1;
         end
         if (addr_push) begin
            addr_buf[{addr_cnt, 3'b000} +: 8] <= PWDATA[7:0];
            addr_cnt <= addr_cnt + 3'd1;
         end
         if (flush_ok || fin) begin
            cmd_cnt  <= '0;
            addr_cnt <= '0;
         end
         if (len_wr)  len_q <= PWDATA[7:0];
         if (ctrl_wr) ie_q  <= PWDATA[CTRL_IE];
         // Hardware set beats a same-cycle W1C
         if (fin)                             done_q <= 1'b1;
         else if (stat_w1c && PWDATA[ST_DONE]) done_q <= 1'b0;
         if ((fin && F_Err) || timeout)       err_q <= 1'b1;
         else if (stat_w1c && PWDATA[ST_ERR])  err_q <= 1'b0;
         irq_q <= ie_q & (done_q | err_q);
      end
   end

`ifdef NFC_TIMEOUT_EN
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] wd_cnt;

   assign timeout = busy && (wd_cnt == WD_LAST);

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         wd_cnt <= '0;
         to_q   <= 1'b0;
      end else begin
         if (start_ok)  wd_cnt <= '0;
         else if (busy) wd_cnt <= wd_cnt + 16'd1;
         if (timeout)                        to_q <= 1'b1;
         else if (stat_w1c && PWDATA[ST_TO]) to_q <= 1'b0;
      end
   end
`else
   assign timeout = 1'b0;
   assign to_q    = 1'b0;
`endif

   always_comb begin
      rdata = '0;
      if (apb_acc && !PWRITE) begin
         case (reg_sel)
            REG_LEN:  rdata[7:0]     = len_q;
            REG_CTRL: rdata[CTRL_IE] = ie_q;
            REG_STATUS: begin
               rdata[ST_BUSY]         = busy;
               rdata[ST_DONE]         = done_q;
               rdata[ST_ERR]          = err_q;
               rdata[ST_RB]           = rb_sync;
               rdata[ST_ACNT +: 3]    = addr_cnt;
               rdata[ST_CCNT +: 2]    = cmd_cnt;
               rdata[ST_TO]           = to_q;
            end
            default: rdata = '0;
         endcase
      end
   end

   assign PRDATA    = rdata;
   assign PREADY    = 1'b1;
   assign PSLVERR   = acc_err;
   assign C_Cmd     = cmd_buf;
   assign C_Addr    = addr_buf;
   assign C_AddrCnt = addr_cnt;
   assign C_Length  = len_q;
   assign C_Start   = start_q;
   assign IRQ       = irq_q;

endmodule
